// File: rtl/spi_pkg.sv
// Shared SPI transfer types: FSM state encoding, mode-bit positions, counter sizing.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spiState_t;

  localparam int MODE_W    = 2;
  localparam int MODE_CPHA = 0;
  localparam int MODE_CPOL = 1;

  // Bits needed to hold any value 0..maxVal.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Host-side request/response bundle of the SPI transfer controller; lsb_first exists only with SPI_LSB_FIRST_EN.
interface spi_xfer_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CS_W   = 2
);
  logic              start;
  logic              ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic [CS_W-1:0]   cs_sel;
  logic              cpol_in;
  logic              cpha_in;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first;

  modport master (output start, tx_data, cs_sel, cpol_in, cpha_in, lsb_first,
                  input  ready, busy, done, rx_data);
  modport slave  (input  start, tx_data, cs_sel, cpol_in, cpha_in, lsb_first,
                  output ready, busy, done, rx_data);
`else
  modport master (output start, tx_data, cs_sel, cpol_in, cpha_in,
                  input  ready, busy, done, rx_data);
  modport slave  (input  start, tx_data, cs_sel, cpol_in, cpha_in,
                  output ready, busy, done, rx_data);
`endif
endinterface

// File: rtl/spi_shift_reg.sv
// TX/RX shift registers for one SPI word; bit order and the CPHA=1 first-shift skip are latched on load.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] loadData,
  input  logic              loadCpha,
  input  logic              loadLsbFirst,
  input  logic              shiftEn,
  input  logic              sampleEn,
  input  logic              miso,
  output logic              txBit,
  output logic [DATA_W-1:0] rxNext
);

  logic [DATA_W-1:0] txReg;
  logic [DATA_W-1:0] rxReg;
  logic              skipFirst;
  logic              lsbFirst;

  // With CPHA=1 the first bit is already on the wire before the first shift edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txReg     <= '0;
      rxReg     <= '0;
      skipFirst <= 1'b0;
      lsbFirst  <= 1'b0;
    end else if (load) begin
      txReg     <= loadData;
      rxReg     <= '0;
      skipFirst <= loadCpha;
      lsbFirst  <= loadLsbFirst;
    end else begin
      if (shiftEn) begin
        if (skipFirst) skipFirst <= 1'b0;
        else           txReg     <= lsbFirst ? (txReg >> 1) : (txReg << 1);
      end
      if (sampleEn) rxReg <= rxNext;
    end
  end

  assign txBit = lsbFirst ? txReg[0] : txReg[DATA_W-1];

  always_comb begin
    rxNext = rxReg;
    if (sampleEn) begin
      rxNext = lsbFirst ? {miso, rxReg[DATA_W-1:1]} : {rxReg[DATA_W-2:0], miso};
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer (CS setup, clocked shift, CS hold); one transfer in flight, start ignored while busy.
// Optional LSB-first ordering via SPI_LSB_FIRST_EN.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_CS   = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_xfer_ctrl_if.slave     host,
  output logic [NUM_CS-1:0]  cs_n,
  output logic               mosi,
  input  logic               miso,
  output logic               en_sclk,
  output logic               cpol,
  output logic               cpha,
  input  logic               shift_edge,
  input  logic               sample_edge
);

  localparam int EDGE_W = cntWidth(2 * DATA_W);
  localparam int TMR_W  = cntWidth((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);

  spiState_t         state, nextState;
  logic [TMR_W-1:0]  tmrCnt;
  logic [EDGE_W-1:0] edgeCnt;
  logic [CS_W-1:0]   csSel;
  logic [MODE_W-1:0] modeReg;
  logic [DATA_W-1:0] rxData;
  logic [DATA_W-1:0] rxNext;
  logic              doneReg;
  logic              accept;
  logic              xferEnd;
  logic              edgePulse;
  logic              txBit;
  logic              lsbFirstIn;

`ifdef SPI_LSB_FIRST_EN
  assign lsbFirstIn = host.lsb_first;
`else
  assign lsbFirstIn = 1'b0;
`endif

  assign edgePulse = (state == ST_XFER) && (shift_edge || sample_edge);

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    xferEnd   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (host.start) begin
          accept    = 1'b1;
          nextState = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmrCnt == TMR_W'(CS_SETUP - 1)) nextState = ST_XFER;
      end
      ST_XFER: begin
        if (edgePulse && (edgeCnt == EDGE_W'(2 * DATA_W - 1))) begin
          xferEnd   = 1'b1;
          nextState = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmrCnt == TMR_W'(CS_HOLD - 1)) nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tmrCnt  <= '0;
      edgeCnt <= '0;
      csSel   <= '0;
      modeReg <= '0;
      rxData  <= '0;
      doneReg <= 1'b0;
    end else begin
      state   <= nextState;
      doneReg <= (state == ST_HOLD) && (nextState == ST_IDLE);

      if (nextState != state)                              tmrCnt <= '0;
      else if ((state == ST_SETUP) || (state == ST_HOLD))  tmrCnt <= tmrCnt + 1'b1;

      if (state != ST_XFER) edgeCnt <= '0;
      else if (edgePulse)   edgeCnt <= edgeCnt + 1'b1;

      // Mode bits persist after the transfer so the SCLK idle level never moves while idle.
      if (accept) begin
        csSel              <= host.cs_sel;
        modeReg[MODE_CPOL] <= host.cpol_in;
        modeReg[MODE_CPHA] <= host.cpha_in;
      end

      // rxNext already contains the final sample when the last edge is a sample edge.
      if (xferEnd) rxData <= rxNext;
    end
  end

  spi_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (accept),
    .loadData     (host.tx_data),
    .loadCpha     (host.cpha_in),
    .loadLsbFirst (lsbFirstIn),
    .shiftEn      ((state == ST_XFER) && shift_edge),
    .sampleEn     ((state == ST_XFER) && sample_edge),
    .miso         (miso),
    .txBit        (txBit),
    .rxNext       (rxNext)
  );

  // Out-of-range selects match no bit, so every chip select stays high.
  always_comb begin
    cs_n = '1;
    if (state != ST_IDLE) begin
      for (int i = 0; i < NUM_CS; i++) cs_n[i] = (csSel != CS_W'(i));
    end
  end

  assign mosi         = (state != ST_IDLE) && txBit;
  assign en_sclk      = (state == ST_XFER);
  assign cpol         = modeReg[MODE_CPOL];
  assign cpha         = modeReg[MODE_CPHA];
  assign host.ready   = (state == ST_IDLE);
  assign host.busy    = (state != ST_IDLE);
  assign host.done    = doneReg;
  assign host.rx_data = rxData;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench: spi_xfer_ctrl with an SCLK generator model (DIV=4, 2-clk pulse lag) and a slave model.
module tb_spi_xfer_ctrl;

  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] cs_n;
  logic       mosi, miso, en_sclk, cpol, cpha;
  logic       shift_edge, sample_edge;

  int checks = 0;
  int errors = 0;

  spi_xfer_ctrl_if #(.DATA_W(8), .CS_W(2)) hostIf ();

  spi_xfer_ctrl #(
    .DATA_W(8), .NUM_CS(4), .CS_SETUP(2), .CS_HOLD(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host(hostIf), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .en_sclk(en_sclk), .cpol(cpol), .cpha(cpha),
    .shift_edge(shift_edge), .sample_edge(sample_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator + slave model
  logic       sclk = 1'b0;
  int         divCnt = 0;
  int         tog = 0;
  logic       p1v = 1'b0, p1s = 1'b0, p2v = 1'b0, p2s = 1'b0;
  logic [7:0] slaveReg = 8'h00;
  logic [7:0] slaveWord = 8'h00;
  logic       loopback = 1'b1;
  logic       isShift;

  assign miso = loopback ? mosi : slaveReg[7];

  always @(posedge clk) begin
    if (&cs_n) slaveReg <= slaveWord;
    if (!en_sclk) begin
      sclk <= cpol; divCnt <= 0; tog <= 0;
      p1v <= 1'b0; p1s <= 1'b0; p2v <= 1'b0; p2s <= 1'b0;
      shift_edge <= 1'b0; sample_edge <= 1'b0;
    end else begin
      p2v <= p1v; p2s <= p1s;
      shift_edge  <= p2v && p2s;
      sample_edge <= p2v && !p2s;
      if (divCnt == DIV - 1) begin
        divCnt  = 0;
        isShift = cpha ? (tog % 2 == 0) : (tog % 2 == 1);
        sclk <= ~sclk;
        tog  <= tog + 1;
        p1v  <= 1'b1;
        p1s  <= isShift;
        if (isShift && !(cpha && tog == 0)) slaveReg <= slaveReg << 1;
      end else begin
        divCnt <= divCnt + 1;
        p1v    <= 1'b0;
      end
    end
  end

  // Monitors
  int         edgeTot = 0;
  int         doneTot = 0;
  logic [7:0] mosiSeq = 8'h00;

  always @(posedge clk) begin
    if (shift_edge || sample_edge) edgeTot <= edgeTot + 1;
    if (hostIf.done) doneTot <= doneTot + 1;
    if (sample_edge) mosiSeq <= {mosiSeq[6:0], mosi};
  end

  task automatic start_xfer(input logic [7:0] tx, input logic [1:0] sel, input logic pol, input logic pha);
    @(posedge clk); #1;
    hostIf.start = 1'b1; hostIf.tx_data = tx; hostIf.cs_sel = sel;
    hostIf.cpol_in = pol; hostIf.cpha_in = pha;
    @(posedge clk); #1;
    hostIf.start = 1'b0;
  endtask

  task automatic wait_done(input int maxCyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxCyc && !seen; i++) begin
      @(negedge clk);
      if (hostIf.done) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({hostIf.ready, hostIf.busy, hostIf.done} !== 3'b100) begin
      errors++; $display("FAIL reset_handshake got %b want 100", {hostIf.ready, hostIf.busy, hostIf.done});
    end
    checks++;
    if (hostIf.rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_rx got %h want 00", hostIf.rx_data);
    end
    checks++;
    if (cs_n !== 4'hF) begin
      errors++; $display("FAIL reset_cs_n got %h want F", cs_n);
    end
    checks++;
    if ({mosi, en_sclk, cpol, cpha} !== 4'b0000) begin
      errors++; $display("FAIL reset_pins got %b want 0000", {mosi, en_sclk, cpol, cpha});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (hostIf.ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b want 1", hostIf.ready);
    end
  endtask

  task automatic test_mode0;
    int  e0, d0;
    bit  seen, enSeen;
    loopback = 1'b1;
    e0 = edgeTot; d0 = doneTot;
    start_xfer(8'hA5, 2'd0, 1'b0, 1'b0);
    enSeen = 1'b0;
    for (int i = 0; i < 50 && !enSeen; i++) begin
      @(negedge clk);
      if (en_sclk) enSeen = 1'b1;
    end
    checks++;
    if (!enSeen || cs_n !== 4'b1110) begin
      errors++; $display("FAIL mode0_cs_n en=%b got %b want 1110", enSeen, cs_n);
    end
    wait_done(300, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL mode0_done_timeout got none want pulse");
    end
    checks++;
    if (hostIf.rx_data !== 8'hA5 || hostIf.ready !== 1'b1) begin
      errors++; $display("FAIL mode0_rx got %h ready %b want A5 ready 1", hostIf.rx_data, hostIf.ready);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (edgeTot - e0 != 16) begin
      errors++; $display("FAIL mode0_edges got %0d want 16", edgeTot - e0);
    end
    checks++;
    if (doneTot - d0 != 1) begin
      errors++; $display("FAIL mode0_done_count got %0d want 1", doneTot - d0);
    end
    checks++;
    if (mosiSeq !== 8'hA5) begin
      errors++; $display("FAIL mode0_mosi_bits got %h want A5", mosiSeq);
    end
    checks++;
    if (cs_n !== 4'hF || mosi !== 1'b0) begin
      errors++; $display("FAIL mode0_idle_pins got cs_n %h mosi %b want F 0", cs_n, mosi);
    end
  endtask

  task automatic test_mode3;
    bit seen;
    loopback = 1'b0;
    slaveWord = 8'hC3;
    start_xfer(8'h3C, 2'd1, 1'b1, 1'b1);
    wait_done(300, seen);
    checks++;
    if (!seen || hostIf.rx_data !== 8'hC3) begin
      errors++; $display("FAIL mode3_rx seen %b got %h want C3", seen, hostIf.rx_data);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mosiSeq !== 8'h3C) begin
      errors++; $display("FAIL mode3_mosi_bits got %h want 3C", mosiSeq);
    end
    checks++;
    if ({cpol, cpha} !== 2'b11 || sclk !== 1'b1) begin
      errors++; $display("FAIL mode3_idle_mode got cpol %b cpha %b sclk %b want 1 1 1", cpol, cpha, sclk);
    end
    loopback = 1'b1;
  endtask

  task automatic test_cs_timing;
    int csLow, enRise, enFall, csHigh;
    logic [3:0] csDuring;
    csLow = -1; enRise = -1; enFall = -1; csHigh = -1; csDuring = 4'hF;
    start_xfer(8'h69, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 300 && csHigh < 0; i++) begin
      @(negedge clk);
      if (csLow < 0 && cs_n[2] == 1'b0) csLow = i;
      if (enRise < 0 && en_sclk) begin enRise = i; csDuring = cs_n; end
      if (enRise >= 0 && enFall < 0 && !en_sclk) enFall = i;
      if (enFall >= 0 && csHigh < 0 && cs_n[2]) csHigh = i;
    end
    checks++;
    if (csLow < 0 || enRise < 0 || enFall < 0 || csHigh < 0) begin
      errors++; $display("FAIL cs_events_timeout got %0d %0d %0d %0d want all seen", csLow, enRise, enFall, csHigh);
    end
    checks++;
    if (enRise - csLow != 2) begin
      errors++; $display("FAIL cs_setup_clks got %0d want 2", enRise - csLow);
    end
    checks++;
    if (csHigh - enFall != 2) begin
      errors++; $display("FAIL cs_hold_clks got %0d want 2", csHigh - enFall);
    end
    checks++;
    if (csDuring !== 4'b1011) begin
      errors++; $display("FAIL cs_sel2_decode got %b want 1011", csDuring);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int d0;
    bit seen;
    d0 = doneTot;
    start_xfer(8'h5A, 2'd1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (hostIf.busy !== 1'b1 || hostIf.ready !== 1'b0) begin
      errors++; $display("FAIL ignore_busy got busy %b ready %b want 1 0", hostIf.busy, hostIf.ready);
    end
    hostIf.start = 1'b1; hostIf.tx_data = 8'hFF; hostIf.cs_sel = 2'd3;
    hostIf.cpol_in = 1'b1; hostIf.cpha_in = 1'b1;
    repeat (3) @(negedge clk);
    hostIf.start = 1'b0; hostIf.cpol_in = 1'b0; hostIf.cpha_in = 1'b0;
    wait_done(300, seen);
    checks++;
    if (!seen || hostIf.rx_data !== 8'h5A) begin
      errors++; $display("FAIL ignore_rx seen %b got %h want 5A", seen, hostIf.rx_data);
    end
    repeat (150) @(negedge clk);
    checks++;
    if (doneTot - d0 != 1) begin
      errors++; $display("FAIL ignore_done_count got %0d want 1", doneTot - d0);
    end
    checks++;
    if ({cpol, cpha} !== 2'b00) begin
      errors++; $display("FAIL ignore_mode got %b want 00", {cpol, cpha});
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    bit seen1, seen2;
    d0 = doneTot;
    start_xfer(8'h96, 2'd0, 1'b0, 1'b0);
    wait_done(300, seen1);
    checks++;
    if (!seen1 || hostIf.rx_data !== 8'h96 || hostIf.ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first seen %b rx %h ready %b want 1 96 1", seen1, hostIf.rx_data, hostIf.ready);
    end
    hostIf.start = 1'b1; hostIf.tx_data = 8'h0F; hostIf.cs_sel = 2'd3;
    @(posedge clk); #1;
    hostIf.start = 1'b0;
    @(negedge clk);
    checks++;
    if (hostIf.busy !== 1'b1 || cs_n !== 4'b0111) begin
      errors++; $display("FAIL b2b_gap got busy %b cs_n %b want 1 0111", hostIf.busy, cs_n);
    end
    wait_done(300, seen2);
    checks++;
    if (!seen2 || hostIf.rx_data !== 8'h0F) begin
      errors++; $display("FAIL b2b_second seen %b rx %h want 0F", seen2, hostIf.rx_data);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (doneTot - d0 != 2) begin
      errors++; $display("FAIL b2b_done_count got %0d want 2", doneTot - d0);
    end
  endtask

  task automatic test_reset_abort;
    int d0, e0;
    bit reached;
    d0 = doneTot; e0 = edgeTot;
    start_xfer(8'hFF, 2'd0, 1'b0, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      if (edgeTot - e0 >= 5) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      errors++; $display("FAIL abort_edge5_timeout got %0d edges want 5", edgeTot - e0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cs_n !== 4'hF || en_sclk !== 1'b0) begin
      errors++; $display("FAIL abort_pins got cs_n %h en %b want F 0", cs_n, en_sclk);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (doneTot != d0) begin
      errors++; $display("FAIL abort_no_done got %0d want 0", doneTot - d0);
    end
    checks++;
    if (hostIf.ready !== 1'b1 || hostIf.rx_data !== 8'h00) begin
      errors++; $display("FAIL abort_after got ready %b rx %h want 1 00", hostIf.ready, hostIf.rx_data);
    end
  endtask

`ifdef SPI_LSB_FIRST_EN
  task automatic test_lsb_first;
    bit seen;
    hostIf.lsb_first = 1'b1;
    start_xfer(8'h01, 2'd0, 1'b0, 1'b0);
    hostIf.lsb_first = 1'b0;
    wait_done(300, seen);
    checks++;
    if (!seen || hostIf.rx_data !== 8'h01) begin
      errors++; $display("FAIL lsb_rx seen %b got %h want 01", seen, hostIf.rx_data);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (mosiSeq !== 8'h80) begin
      errors++; $display("FAIL lsb_mosi_order got %h want 80", mosiSeq);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    hostIf.start = 1'b0; hostIf.tx_data = 8'h00; hostIf.cs_sel = 2'd0;
    hostIf.cpol_in = 1'b0; hostIf.cpha_in = 1'b0;
`ifdef SPI_LSB_FIRST_EN
    hostIf.lsb_first = 1'b0;
`endif
    repeat (3) @(negedge clk);
    test_reset;
    test_mode0;
    test_mode3;
    test_cs_timing;
    test_start_ignored;
    test_back_to_back;
    test_reset_abort;
`ifdef SPI_LSB_FIRST_EN
    test_lsb_first;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
